// File: rtl/sys_bridge.sv
// CPU-side system bridge: decodes DM / TIMER0 / TIMER1 / INT ranges, builds store lanes,
// flags illegal stores, and returns one-cycle-latency read data that holds across stalls.
module sys_bridge #(
   parameter logic [31:0] DM_LSA  = 32'h0000_0000,
   parameter logic [31:0] DM_MSA  = 32'h0000_2FFF,
   parameter logic [31:0] TC0_LSA = 32'h0000_7F00,
   parameter logic [31:0] TC0_MSA = 32'h0000_7F0B,
   parameter logic [31:0] TC1_LSA = 32'h0000_7F10,
   parameter logic [31:0] TC1_MSA = 32'h0000_7F1B,
   parameter logic [31:0] INT_LSA = 32'h0000_7F20,
   parameter logic [31:0] INT_MSA = 32'h0000_7F23
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [2:0]  cpu_st_op,
   input  logic        cpu_ld,
   input  logic        cpu_stall,
   input  logic        cpu_flush,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_byteen,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   output logic [29:0] tc0_addr,
   output logic        tc0_we,
   output logic [31:0] tc0_wdata,
   input  logic [31:0] tc0_rdata,
   output logic [29:0] tc1_addr,
   output logic        tc1_we,
   output logic [31:0] tc1_wdata,
   input  logic [31:0] tc1_rdata,
   output logic        int_ack,
   output logic        st_exc,
   output logic [31:0] rdata_out
);

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_DM,
      SEL_TC0,
      SEL_TC1,
      SEL_INT
   } sel_t;

   sel_t        sel_q;
   logic [31:0] tc_q;

   logic        hit_dm, hit_tc0, hit_tc1, hit_int, hit_tc, unmapped;
   logic        is_sw, is_sh, is_sb, is_store;
   logic        wr_ok;
   logic [3:0]  byteen_raw;
   logic [31:0] lane_data;
   sel_t        target;

   // Offset compare keeps inclusive ranges correct even when LSA is zero.
   function automatic logic in_range(input logic [31:0] a, input logic [31:0] lsa,
                                     input logic [31:0] msa);
      return (a - lsa) <= (msa - lsa);
   endfunction

   always_comb begin
      hit_dm   = in_range(cpu_addr, DM_LSA, DM_MSA);
      hit_tc0  = in_range(cpu_addr, TC0_LSA, TC0_MSA);
      hit_tc1  = in_range(cpu_addr, TC1_LSA, TC1_MSA);
      hit_int  = in_range(cpu_addr, INT_LSA, INT_MSA);
      hit_tc   = hit_tc0 | hit_tc1;
      unmapped = ~(hit_dm | hit_tc | hit_int);

      is_sw    = (cpu_st_op == 3'd1);
      is_sh    = (cpu_st_op == 3'd2);
      is_sb    = (cpu_st_op == 3'd3);
      is_store = is_sw | is_sh | is_sb;

      st_exc = is_store & (unmapped
                           | (is_sw & (cpu_addr[1:0] != 2'b00))
                           | (is_sh & cpu_addr[0])
                           | ((is_sh | is_sb) & hit_tc)
                           | (hit_tc & (cpu_addr[3:2] == 2'b10)));

      wr_ok = is_store & ~st_exc & ~cpu_flush & reset;

      byteen_raw = '0;
      lane_data  = '0;
      if (is_sw) begin
         byteen_raw = 4'b1111;
         lane_data  = cpu_wdata;
      end else if (is_sh) begin
         byteen_raw = cpu_addr[1] ? 4'b1100 : 4'b0011;
         lane_data  = {2{cpu_wdata[15:0]}};
      end else if (is_sb) begin
         byteen_raw = 4'b0001 << cpu_addr[1:0];
         lane_data  = {4{cpu_wdata[7:0]}};
      end

      dm_addr   = cpu_addr;
      dm_byteen = (wr_ok & hit_dm) ? byteen_raw : 4'b0000;
      dm_wdata  = lane_data;
      tc0_addr  = cpu_addr[31:2];
      tc0_we    = wr_ok & hit_tc0 & is_sw;
      tc0_wdata = lane_data;
      tc1_addr  = cpu_addr[31:2];
      tc1_we    = wr_ok & hit_tc1 & is_sw;
      tc1_wdata = lane_data;

      // A load that is also a store is treated as a store: no read is tracked.
      target = SEL_NONE;
      if (cpu_ld && !is_store) begin
         if (hit_dm)       target = SEL_DM;
         else if (hit_tc0) target = SEL_TC0;
         else if (hit_tc1) target = SEL_TC1;
         else if (hit_int) target = SEL_INT;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sel_q   <= SEL_NONE;
         tc_q    <= '0;
         int_ack <= 1'b0;
      end else begin
         int_ack <= wr_ok & hit_int & ~int_ack;
         if (!cpu_stall) begin
            sel_q <= target;
            if (hit_tc0)      tc_q <= tc0_rdata;
            else if (hit_tc1) tc_q <= tc1_rdata;
         end
      end
   end

   always_comb begin
      rdata_out = '0;
      case (sel_q)
         SEL_DM:           rdata_out = dm_rdata;
         SEL_TC0, SEL_TC1: rdata_out = tc_q;
         default:          rdata_out = '0;
      endcase
   end

endmodule

// File: tb/tb_sys_bridge.sv
// Directed scoreboard bench for sys_bridge: expectations are queued at drive time
// and popped when the corresponding output is sampled.
module tb_sys_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cpu_addr, cpu_wdata;
   logic [2:0]  cpu_st_op;
   logic        cpu_ld, cpu_stall, cpu_flush;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic [3:0]  dm_byteen;
   logic [29:0] tc0_addr, tc1_addr;
   logic        tc0_we, tc1_we;
   logic [31:0] tc0_wdata, tc1_wdata, tc0_rdata, tc1_rdata;
   logic        int_ack, st_exc;
   logic [31:0] rdata_out;

   typedef struct {
      string       tag;
      logic [31:0] v;
   } exp_t;

   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;

   localparam logic [2:0] OP_NONE = 3'd0, OP_SW = 3'd1, OP_SH = 3'd2, OP_SB = 3'd3;
   localparam logic [31:0] DM_DATA = 32'hDEAD_BEEF;

   always #5 clk = ~clk;

   sys_bridge dut (
      .clk(clk), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_st_op(cpu_st_op),
      .cpu_ld(cpu_ld), .cpu_stall(cpu_stall), .cpu_flush(cpu_flush),
      .dm_addr(dm_addr), .dm_byteen(dm_byteen), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
      .tc0_addr(tc0_addr), .tc0_we(tc0_we), .tc0_wdata(tc0_wdata), .tc0_rdata(tc0_rdata),
      .tc1_addr(tc1_addr), .tc1_we(tc1_we), .tc1_wdata(tc1_wdata), .tc1_rdata(tc1_rdata),
      .int_ack(int_ack), .st_exc(st_exc), .rdata_out(rdata_out)
   );

   task automatic push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      sb_q.push_back(e);
   endtask

   task automatic chk(input logic [31:0] obs);
      exp_t e;
      tests++;
      if (sb_q.size() == 0) begin
         fails++;
         $error("FAIL scoreboard_empty observed=%h expected=<queued value>", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.v) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                        input logic ld);
      cpu_st_op = op;
      cpu_addr  = a;
      cpu_wdata = d;
      cpu_ld    = ld;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; cpu_stall = 1'b0; cpu_flush = 1'b0;
      dm_rdata = DM_DATA; tc0_rdata = '0; tc1_rdata = '0;
      drive(OP_SW, 32'h0000_0000, 32'h1111_1111, 1'b0);
      tick(); tick();

      push("reset_rdata", 32'h0);   chk(rdata_out);
      push("reset_int_ack", 32'h0); chk({31'b0, int_ack});
      push("reset_byteen_off", 32'h0); chk({28'b0, dm_byteen});

      reset = 1'b1;
      // SB to byte 3 of DM word
      drive(OP_SB, 32'h0000_0013, 32'h0000_00A5, 1'b0);
      push("sb_byteen", 32'h8);          chk({28'b0, dm_byteen});
      push("sb_wdata", 32'hA5A5_A5A5);   chk(dm_wdata);
      push("sb_exc", 32'h0);             chk({31'b0, st_exc});
      push("dm_addr", 32'h0000_0013);    chk(dm_addr);

      drive(OP_SH, 32'h0000_0012, 32'h0000_BEEF, 1'b0);
      push("sh_hi_byteen", 32'hC);       chk({28'b0, dm_byteen});
      push("sh_wdata", 32'hBEEF_BEEF);   chk(dm_wdata);

      drive(OP_SW, 32'h0000_2FFC, 32'h1234_5678, 1'b0);
      push("sw_dm_top_byteen", 32'hF);   chk({28'b0, dm_byteen});
      push("sw_wdata", 32'h1234_5678);   chk(dm_wdata);

      // Illegal stores
      drive(OP_SH, 32'h0000_0011, 32'h0, 1'b0);
      push("sh_odd_exc", 32'h1);         chk({31'b0, st_exc});
      push("sh_odd_byteen", 32'h0);      chk({28'b0, dm_byteen});
      drive(OP_SW, 32'h0000_7F08, 32'h0, 1'b0);
      push("sw_count_exc", 32'h1);       chk({31'b0, st_exc});
      push("sw_count_we", 32'h0);        chk({31'b0, tc0_we});
      drive(OP_SW, 32'h0000_0002, 32'h0, 1'b0);
      push("sw_misalign_exc", 32'h1);    chk({31'b0, st_exc});
      drive(OP_SB, 32'h0000_7F14, 32'h0, 1'b0);
      push("sb_timer_exc", 32'h1);       chk({31'b0, st_exc});
      push("sb_timer_we", 32'h0);        chk({31'b0, tc1_we});
      drive(OP_SW, 32'h0000_3000, 32'h0, 1'b0);
      push("sw_unmapped_exc", 32'h1);    chk({31'b0, st_exc});
      push("sw_unmapped_byteen", 32'h0); chk({28'b0, dm_byteen});

      // Timer stores
      drive(OP_SW, 32'h0000_7F04, 32'h0000_0064, 1'b0);
      push("tc0_we", 32'h1);             chk({31'b0, tc0_we});
      push("tc0_addr", 32'h0000_1FC1);   chk({2'b0, tc0_addr});
      push("tc0_wdata", 32'h64);         chk(tc0_wdata);
      push("tc0_no_tc1_we", 32'h0);      chk({31'b0, tc1_we});
      cpu_flush = 1'b1; #1;
      push("tc0_flush_we", 32'h0);       chk({31'b0, tc0_we});
      cpu_flush = 1'b0;
      drive(OP_SW, 32'h0000_7F14, 32'h0, 1'b0);
      push("tc1_we", 32'h1);             chk({31'b0, tc1_we});

      // Timer load holds across stall
      drive(OP_NONE, 32'h0000_7F18, 32'h0, 1'b1);
      tc1_rdata = 32'h0000_1234;
      push("ld_exc", 32'h0);             chk({31'b0, st_exc});
      tick();
      push("tc1_ld_rdata", 32'h1234);    chk(rdata_out);
      cpu_stall = 1'b1; cpu_ld = 1'b0; tc1_rdata = 32'h0000_9999;
      for (int i = 0; i < 3; i++) begin
         tick();
         push("tc1_ld_stall_hold", 32'h1234); chk(rdata_out);
      end
      cpu_stall = 1'b0;
      drive(OP_NONE, 32'h0000_0000, 32'h0, 1'b0);
      tick();
      push("no_ld_rdata", 32'h0);        chk(rdata_out);

      // DM, unmapped, TC0, INT loads
      drive(OP_NONE, 32'h0000_0100, 32'h0, 1'b1);
      tick();
      push("dm_ld_rdata", DM_DATA);      chk(rdata_out);
      drive(OP_NONE, 32'h0000_3000, 32'h0, 1'b1);
      push("unmapped_ld_exc", 32'h0);    chk({31'b0, st_exc});
      tick();
      push("unmapped_ld_rdata", 32'h0);  chk(rdata_out);
      tc0_rdata = 32'h0000_AAAA;
      drive(OP_NONE, 32'h0000_7F00, 32'h0, 1'b1);
      tick();
      push("tc0_ld_rdata", 32'hAAAA);    chk(rdata_out);
      drive(OP_NONE, 32'h0000_7F20, 32'h0, 1'b1);
      tick();
      push("int_ld_rdata", 32'h0);       chk(rdata_out);
      // load combined with a store tracks nothing
      drive(OP_SW, 32'h0000_0100, 32'h0, 1'b1);
      tick();
      push("ld_st_rdata", 32'h0);        chk(rdata_out);

      // INT ack pulse
      drive(OP_SW, 32'h0000_7F20, 32'h0, 1'b0);
      tick();
      push("int_ack_set", 32'h1);        chk({31'b0, int_ack});
      drive(OP_NONE, 32'h0, 32'h0, 1'b0);
      tick();
      push("int_ack_clear", 32'h0);      chk({31'b0, int_ack});
      drive(OP_SW, 32'h0000_7F20, 32'h0, 1'b0);
      cpu_flush = 1'b1;
      tick();
      push("int_ack_flushed", 32'h0);    chk({31'b0, int_ack});
      cpu_flush = 1'b0;

      // Reset during a stalled DM load discards it
      drive(OP_NONE, 32'h0000_0100, 32'h0, 1'b1);
      tick();
      push("dm_ld_before_rst", DM_DATA); chk(rdata_out);
      cpu_stall = 1'b1; cpu_ld = 1'b0; reset = 1'b0;
      tick();
      reset = 1'b1;
      push("rst_stall_rdata", 32'h0);    chk(rdata_out);
      push("rst_stall_int_ack", 32'h0);  chk({31'b0, int_ack});
      tick();
      push("rst_stall_rdata_hold", 32'h0); chk(rdata_out);
      cpu_stall = 1'b0;

      if (sb_q.size() != 0) begin
         tests++;
         fails++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
